// File: rtl/llr_deint_pkg.sv
// rtl/llr_deint_pkg.sv - shared types, sizing and address permutation for the LLR deinterleaver
package llr_deint_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam int ROWS_LOG_DEF = 4;
  localparam int COLS_LOG_DEF = 6;
  localparam int N_DEF        = 1 << (ROWS_LOG_DEF + COLS_LOG_DEF);

  // Block length for a given row/column geometry.
  function automatic int blk_len(input int rows_log, input int cols_log);
    return 1 << (rows_log + cols_log);
  endfunction

  // Read index k -> RAM address. Column-major: row = k mod rows, col = k / rows,
  // and the bank is stored row-major, so address = row * cols + col.
  function automatic logic [31:0] deint_addr(input logic [31:0] k, input logic bypass,
                                             input int rows_log, input int cols_log);
    logic [31:0] row;
    logic [31:0] col;
    row = k & ((32'd1 << rows_log) - 32'd1);
    col = (k >> rows_log) & ((32'd1 << cols_log) - 32'd1);
    return bypass ? k : ((row << cols_log) | col);
  endfunction

endpackage

// File: rtl/llr_skid_fifo.sv
// rtl/llr_skid_fifo.sv - 2-entry valid/ready skid buffer on the deinterleaver output
module llr_skid_fifo #(
  parameter int pW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  input  logic [pW-1:0] s_tdata,
  output logic          m_tvalid,
  output logic [pW-1:0] m_tdata,
  input  logic          m_tready,
  output logic [1:0]    count
);

  logic [pW-1:0] mem0;
  logic [pW-1:0] mem1;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push;
  logic          pop;
  logic [1:0]    count_nxt;

  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = rd_ptr ? mem1 : mem0;

  // Push/pop decode and occupancy update; the upstream never pushes into a full buffer.
  always_comb begin
    push      = s_tvalid;
    pop       = m_tvalid & m_tready;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Entry storage and pointers; head entry only moves on a pop so data holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= s_tdata;
        else        mem0 <= s_tdata;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/llr_deinterleaver.sv
// rtl/llr_deinterleaver.sv - ping-pong row/column LLR deinterleaver (optional LLR_DEINT_BYPASS_EN adds ibypass)
module llr_deinterleaver
  import llr_deint_pkg::*;
#(
  parameter int pLLR_W    = 5,
  parameter int pROWS_LOG = ROWS_LOG_DEF,
  parameter int pCOLS_LOG = COLS_LOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LLR_DEINT_BYPASS_EN
  input  logic              ibypass,
`endif
  input  logic              ifrm_start,
  input  logic              s_ax_ival,
  input  logic [pLLR_W-1:0] s_ax_idata,
  output logic              m_ax_oval,
  output logic [pLLR_W-1:0] m_ax_odata,
  output logic              m_ax_olast,
  input  logic              m_ax_irdy,
  output logic [1:0]        ofill,
  output logic              ooverflow
);

  localparam int            KW   = pROWS_LOG + pCOLS_LOG;
  localparam int            N    = blk_len(pROWS_LOG, pCOLS_LOG);
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  logic [pLLR_W-1:0] ram [0:2*N-1];

  logic [KW-1:0]   w;
  logic [KW-1:0]   w_eff;
  logic            wr_bank;
  logic            wr_en;
  logic            fill;
  logic [1:0]      ofill_nxt;

  rd_state_t       state;
  rd_state_t       state_nxt;
  logic [KW-1:0]   k;
  logic [KW-1:0]   rd_addr;
  logic            rd_bank;
  logic            rd_en;
  logic            bank_rel;
  logic            issue_ok;
  logic            rd_vld;
  logic            rd_last;
  logic [pLLR_W-1:0] rd_data;
  logic            bypass_q;

  logic [1:0]      fifo_cnt;
  logic            pop;
  logic [pLLR_W:0] fifo_out;

  assign pop        = m_ax_oval & m_ax_irdy;
  assign m_ax_odata = fifo_out[pLLR_W-1:0];
  assign m_ax_olast = fifo_out[pLLR_W];
  assign rd_addr    = KW'(deint_addr(32'(k), bypass_q, pROWS_LOG, pCOLS_LOG));

  // A new read may issue only if the buffer can absorb it two cycles later, counting
  // what already sits in the RAM read register and what leaves this cycle.
  assign issue_ok = (({1'b0, fifo_cnt} + {2'b00, rd_vld} - {2'b00, pop}) <= 3'd1);

  // Write side: resync, accept/drop decision and bank-full detection. A bank being
  // released on this same edge may take the first LLR of the next fill.
  always_comb begin
    w_eff     = ifrm_start ? '0 : w;
    wr_en     = s_ax_ival && ((ofill != 2'd2) || bank_rel);
    fill      = wr_en && (w_eff == LAST);
    ofill_nxt = ofill;
    case ({fill, bank_rel})
      2'b10:   ofill_nxt = ofill + 2'd1;
      2'b01:   ofill_nxt = ofill - 2'd1;
      default: ofill_nxt = ofill;
    endcase
  end

  // Read FSM next state. When the other bank is already full at the last issue, the
  // current bank is released right away so the next block streams without a bubble.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    bank_rel  = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (ofill != 2'd0) state_nxt = RD_RUN;
      end
      RD_RUN: begin
        if (issue_ok) begin
          rd_en = 1'b1;
          if (k == LAST) begin
            if (ofill == 2'd2) bank_rel  = 1'b1;
            else               state_nxt = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (pop && m_ax_olast) begin
          bank_rel  = 1'b1;
          state_nxt = ((ofill == 2'd2) || (s_ax_ival && (w_eff == LAST))) ? RD_RUN : RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Ping-pong storage with a registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) ram[{wr_bank, w_eff}] <= s_ax_idata;
    if (rd_en) rd_data <= ram[{rd_bank, rd_addr}];
  end

  // Write index, write bank, fill count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w         <= '0;
      wr_bank   <= 1'b0;
      ofill     <= 2'd0;
      ooverflow <= 1'b0;
    end else begin
      if (wr_en) begin
        if (fill) begin
          w       <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          w <= w_eff + KW'(1);
        end
      end else if (ifrm_start) begin
        w <= '0;
      end
      ofill <= ofill_nxt;
      if (s_ax_ival && !wr_en) ooverflow <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  // Read index, read bank and RAM-output valid/last tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      rd_bank <= 1'b0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_last <= (k == LAST);
        k       <= (k == LAST) ? '0 : k + KW'(1);
      end
      if (bank_rel) rd_bank <= ~rd_bank;
    end
  end

`ifdef LLR_DEINT_BYPASS_EN
  // Bypass mode is latched at the start of each block and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if ((state_nxt == RD_RUN) && ((state != RD_RUN) || bank_rel)) begin
      bypass_q <= ibypass;
    end
  end
`else
  assign bypass_q = 1'b0;
`endif

  llr_skid_fifo #(
    .pW(pLLR_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (rd_vld),
    .s_tdata  ({rd_last, rd_data}),
    .m_tvalid (m_ax_oval),
    .m_tdata  (fifo_out),
    .m_tready (m_ax_irdy),
    .count    (fifo_cnt)
  );

endmodule
